// File: rtl/alu_exec_unit.sv
`default_nettype none
// ============================================================================
// Module   : alu_exec_unit
// Brief    : Registered ALU execute stage with {V,N,C,Z} flags register and
//            branch-condition evaluation. ALU_SERIAL_SHIFT_EN selects the
//            multi-cycle barrel-free shifter (shift by src_b[2:0]).
// Revision : 1.0 - initial release
// ============================================================================
module alu_exec_unit #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [2:0]            alu_control,
  input  logic [DATA_WIDTH-1:0] src_a,
  input  logic [DATA_WIDTH-1:0] src_b,
  input  logic                  flags_we,
  input  logic                  flags_load,
  input  logic [3:0]            flags_in,
  input  logic [2:0]            cond,
  output logic [DATA_WIDTH-1:0] result,
  output logic [3:0]            flags,
  output logic                  busy,
  output logic                  done,
  output logic                  branch_taken
);

  localparam int MSB = DATA_WIDTH - 1;

  localparam logic [2:0] c_OP_ADD = 3'b000;
  localparam logic [2:0] c_OP_SUB = 3'b001;
  localparam logic [2:0] c_OP_AND = 3'b010;
  localparam logic [2:0] c_OP_OR  = 3'b011;
  localparam logic [2:0] c_OP_XOR = 3'b100;
  localparam logic [2:0] c_OP_LSL = 3'b101;
  localparam logic [2:0] c_OP_LSR = 3'b110;

  // Single-bit shift step: returns {carry_out, shifted_value}
  function automatic logic [DATA_WIDTH:0] shift1(input logic [2:0] op, input logic [MSB:0] v);
    case (op)
      c_OP_LSL: shift1 = {v[MSB], v[MSB-1:0], 1'b0};
      c_OP_LSR: shift1 = {v[0], 1'b0, v[MSB:1]};
      default:  shift1 = {v[0], v[MSB], v[MSB:1]};
    endcase
  endfunction

  function automatic logic [3:0] pack_flags(input logic [MSB:0] r, input logic c, input logic v);
    pack_flags = {v, r[MSB], c, (r == '0)};
  endfunction

  logic [DATA_WIDTH:0] w_sum;
  logic [DATA_WIDTH:0] w_diff;
  logic [MSB:0]        w_res;
  logic                w_c;
  logic                w_v;

  logic                w_done_nxt;
  logic [MSB:0]        w_res_nxt;
  logic                w_c_nxt;
  logic                w_v_nxt;
  logic                w_fwe_nxt;

  logic [MSB:0]        r_result;
  logic [3:0]          r_flags;
  logic                r_done;

  assign w_sum  = {1'b0, src_a} + {1'b0, src_b};
  assign w_diff = {1'b0, src_a} - {1'b0, src_b};

`ifdef ALU_SERIAL_SHIFT_EN
  // Immediate path sees a shift only when the amount is zero: pass A through.
  localparam logic c_SERIAL = 1'b1;
`else
  localparam logic c_SERIAL = 1'b0;
  logic [DATA_WIDTH:0] w_sh_a;
  assign w_sh_a = shift1(alu_control, src_a);
`endif

  always_comb begin
    w_res = src_a;
    w_c   = 1'b0;
    w_v   = 1'b0;
    case (alu_control)
      c_OP_ADD: begin
        w_res = w_sum[MSB:0];
        w_c   = w_sum[DATA_WIDTH];
        w_v   = (src_a[MSB] == src_b[MSB]) && (w_sum[MSB] != src_a[MSB]);
      end
      c_OP_SUB: begin
        w_res = w_diff[MSB:0];
        w_c   = w_diff[DATA_WIDTH];
        w_v   = (src_a[MSB] != src_b[MSB]) && (w_diff[MSB] != src_a[MSB]);
      end
      c_OP_AND: w_res = src_a & src_b;
      c_OP_OR:  w_res = src_a | src_b;
      c_OP_XOR: w_res = src_a ^ src_b;
      default: begin
        if (!c_SERIAL) begin
`ifndef ALU_SERIAL_SHIFT_EN
          w_res = w_sh_a[MSB:0];
          w_c   = w_sh_a[DATA_WIDTH];
`endif
        end
      end
    endcase
  end

`ifdef ALU_SERIAL_SHIFT_EN
  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [2:0]          r_cnt;
  logic [MSB:0]        r_sh;
  logic [2:0]          r_op;
  logic                r_fwe;
  logic                w_is_shift;
  logic                w_launch;
  logic                w_imm;
  logic                w_fin;
  logic [DATA_WIDTH:0] w_step;

  assign w_is_shift = alu_control[2] & (alu_control[1:0] != 2'b00);
  assign w_step     = shift1(r_op, r_sh);

  always_comb begin
    w_state_nxt = r_state;
    w_launch    = 1'b0;
    w_imm       = 1'b0;
    w_fin       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          if (w_is_shift && (src_b[2:0] != 3'd0)) begin
            w_launch    = 1'b1;
            w_state_nxt = S_SHIFT;
          end else begin
            w_imm = 1'b1;
          end
        end
      end
      S_SHIFT: begin
        if (r_cnt == 3'd1) begin
          w_fin       = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= 3'd0;
      r_sh  <= '0;
      r_op  <= 3'd0;
      r_fwe <= 1'b0;
    end else if (w_launch) begin
      r_cnt <= src_b[2:0];
      r_sh  <= src_a;
      r_op  <= alu_control;
      r_fwe <= flags_we;
    end else if (r_state == S_SHIFT) begin
      r_cnt <= r_cnt - 3'd1;
      r_sh  <= w_step[MSB:0];
    end
  end

  // The last step's shifted-out bit becomes C; V is always clear for shifts.
  assign w_done_nxt = w_imm | w_fin;
  assign w_res_nxt  = w_fin ? w_step[MSB:0] : w_res;
  assign w_c_nxt    = w_fin ? w_step[DATA_WIDTH] : w_c;
  assign w_v_nxt    = w_fin ? 1'b0 : w_v;
  assign w_fwe_nxt  = w_fin ? r_fwe : flags_we;
  assign busy       = (r_state == S_SHIFT);
`else
  assign w_done_nxt = start;
  assign w_res_nxt  = w_res;
  assign w_c_nxt    = w_c;
  assign w_v_nxt    = w_v;
  assign w_fwe_nxt  = flags_we;
  assign busy       = 1'b0;
`endif

  // flags_load takes priority over a same-edge operation commit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_result <= '0;
      r_flags  <= 4'd0;
      r_done   <= 1'b0;
    end else begin
      r_done <= w_done_nxt;
      if (w_done_nxt) r_result <= w_res_nxt;
      if (flags_load)
        r_flags <= flags_in;
      else if (w_done_nxt && w_fwe_nxt)
        r_flags <= pack_flags(w_res_nxt, w_c_nxt, w_v_nxt);
    end
  end

  always_comb begin
    branch_taken = 1'b0;
    case (cond)
      3'b000:  branch_taken = r_flags[0];
      3'b001:  branch_taken = ~r_flags[0];
      3'b010:  branch_taken = r_flags[1];
      3'b011:  branch_taken = ~r_flags[1];
      3'b100:  branch_taken = r_flags[2] ^ r_flags[3];
      3'b101:  branch_taken = 1'b1;
      default: branch_taken = 1'b0;
    endcase
  end

  assign result = r_result;
  assign flags  = r_flags;
  assign done   = r_done;

endmodule
`default_nettype wire
